// File: rtl/cnn_mac_seq.sv
// cnn_mac_seq: sequential signed dot-product engine.
// A job runs as follows:
//   1. On ap_start the block latches a beat count and loads a bias into the accumulator.
//   2. It streams in `len` operand pairs through a valid/ready handshake.
//   3. Each accepted pair is multiplied at full precision into a one-stage product register.
//   4. The accumulator sums the products and wraps on overflow.
//   5. The result is held on a valid/ready output until it is taken.
module cnn_mac_seq #(
    parameter int DIN0_WIDTH = 14,
    parameter int DIN1_WIDTH = 7,
    parameter int ACC_WIDTH  = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ap_start,
    output logic                         ap_ready,
    output logic                         ap_idle,
    output logic                         ap_done,
    input  logic [LEN_WIDTH-1:0]         len,
    input  logic signed [ACC_WIDTH-1:0]  bias,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic signed [ACC_WIDTH-1:0]  res_data
);

    localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                        state;
    logic [LEN_WIDTH-1:0]          len_q;
    logic [LEN_WIDTH-1:0]          cnt;
    logic signed [PROD_WIDTH-1:0]  prod_p1;
    logic                          vld_p1;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic                          beat;
    logic                          last_beat;

    // Full-precision signed multiply: both operands widened to the product width first
    function automatic logic signed [PROD_WIDTH-1:0] mul_full(
        input logic signed [DIN0_WIDTH-1:0] a,
        input logic signed [DIN1_WIDTH-1:0] b
    );
        logic signed [PROD_WIDTH-1:0] ax;
        logic signed [PROD_WIDTH-1:0] bx;
        ax = PROD_WIDTH'(a);
        bx = PROD_WIDTH'(b);
        return ax * bx;
    endfunction

    // Sign-extend a product to accumulator width
    function automatic logic signed [ACC_WIDTH-1:0] sext_acc(
        input logic signed [PROD_WIDTH-1:0] p
    );
        return ACC_WIDTH'(p);
    endfunction

    assign beat      = (state == RUN) && in_valid;
    assign last_beat = beat && ((cnt + LEN_WIDTH'(1)) == len_q);

    assign ap_idle   = (state == IDLE);
    assign in_ready  = (state == RUN);
    assign res_valid = (state == OUT);
    // ap_ready is masked by reset so that a held ap_start cannot pulse it during reset
    assign ap_ready  = (state == IDLE) && ap_start && ap_rst_n;
    assign ap_done   = (state == OUT) && res_ready;
    assign res_data  = acc;

    // Stage p1: register the product of each transferred beat together with its valid flag
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            prod_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= beat;
            if (beat) begin
                prod_p1 <= mul_full(din0, din1);
            end
        end
    end

    // Control FSM and accumulator: bias load on accept, product accumulation, result hold
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
            len_q <= '0;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            if (vld_p1) begin
                acc <= acc + sext_acc(prod_p1);
            end
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        len_q <= len;
                        cnt   <= '0;
                        acc   <= bias;
                        state <= (len == '0) ? OUT : RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        cnt <= cnt + LEN_WIDTH'(1);
                    end
                    if (last_beat) begin
                        state <= DRAIN;
                    end
                end
                // The last product is added to the accumulator during this cycle
                DRAIN: begin
                    state <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_mac_seq.sv
// tb_cnn_mac_seq: directed bench for cnn_mac_seq (default widths plus a 21-bit accumulator instance).
module tb_cnn_mac_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // default-parameter instance
    logic               ap_start, ap_ready, ap_idle, ap_done;
    logic [7:0]         len;
    logic signed [31:0] bias;
    logic               in_valid, in_ready;
    logic signed [13:0] din0;
    logic signed [6:0]  din1;
    logic               res_valid, res_ready;
    logic signed [31:0] res_data;

    // narrow-accumulator instance
    logic               w_ap_start, w_ap_ready, w_ap_idle, w_ap_done;
    logic [7:0]         w_len;
    logic signed [20:0] w_bias;
    logic               w_in_valid, w_in_ready;
    logic signed [13:0] w_din0;
    logic signed [6:0]  w_din1;
    logic               w_res_valid, w_res_ready;
    logic signed [20:0] w_res_data;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cnn_mac_seq dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_idle(ap_idle), .ap_done(ap_done), .len(len), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .din0(din0), .din1(din1),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    cnn_mac_seq #(.ACC_WIDTH(21)) dut_w (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(w_ap_start), .ap_ready(w_ap_ready),
        .ap_idle(w_ap_idle), .ap_done(w_ap_done), .len(w_len), .bias(w_bias),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .din0(w_din0), .din1(w_din1),
        .res_valid(w_res_valid), .res_ready(w_res_ready), .res_data(w_res_data)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ap_start = 1'b0; len = 8'd0; bias = 32'sd0; in_valid = 1'b0;
        din0 = 14'sd0; din1 = 7'sd0; res_ready = 1'b0;
        w_ap_start = 1'b0; w_len = 8'd0; w_bias = 21'sd0; w_in_valid = 1'b0;
        w_din0 = 14'sd0; w_din1 = 7'sd0; w_res_ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_idle", ap_idle, 1'b1);
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_res_valid", res_valid, 1'b0);
        check_bit("rst_ap_done", ap_done, 1'b0);
        check_bit("rst_ap_ready", ap_ready, 1'b0);
        check_val("rst_res_data", 64'(res_data), 64'sd0);
        rst_n = 1'b1;
        tick;

        // three back-to-back beats: 10 + 200 - 150 - 524224
        ap_start = 1'b1; len = 8'd3; bias = 32'sd10; res_ready = 1'b1;
        #1;
        check_bit("t1_ap_ready", ap_ready, 1'b1);
        check_bit("t1_idle_in_ready", in_ready, 1'b0);
        tick;
        ap_start = 1'b0;
        #1;
        check_bit("t1_run_in_ready", in_ready, 1'b1);
        check_bit("t1_run_idle", ap_idle, 1'b0);
        check_bit("t1_run_ap_ready", ap_ready, 1'b0);
        in_valid = 1'b1; din0 = 14'sd100; din1 = 7'sd2;
        tick;
        din0 = -14'sd50; din1 = 7'sd3;
        tick;
        din0 = 14'sd8191; din1 = -7'sd64;
        tick;
        in_valid = 1'b0;
        #1;
        check_bit("t1_t1_in_ready", in_ready, 1'b0);
        check_bit("t1_t1_res_valid", res_valid, 1'b0);
        tick;
        #1;
        check_bit("t1_t2_res_valid", res_valid, 1'b1);
        check_val("t1_res_data", 64'(res_data), -64'sd524164);
        check_bit("t1_ap_done", ap_done, 1'b1);
        tick;
        #1;
        check_bit("t1_after_done", ap_done, 1'b0);
        check_bit("t1_back_idle", ap_idle, 1'b1);
        check_bit("t1_after_res_valid", res_valid, 1'b0);

        // zero-length job returns the bias
        res_ready = 1'b0; ap_start = 1'b1; len = 8'd0; bias = -32'sd7;
        tick;
        ap_start = 1'b0;
        #1;
        check_bit("t2_in_ready", in_ready, 1'b0);
        check_bit("t2_res_valid", res_valid, 1'b1);
        check_val("t2_res_data", 64'(res_data), -64'sd7);
        check_bit("t2_no_done", ap_done, 1'b0);
        res_ready = 1'b1;
        #1;
        check_bit("t2_ap_done", ap_done, 1'b1);
        tick;
        res_ready = 1'b0;
        #1;
        check_bit("t2_idle", ap_idle, 1'b1);
        check_bit("t2_done_low", ap_done, 1'b0);

        // four beats with in_valid toggling: 4 * 524288
        ap_start = 1'b1; len = 8'd4; bias = 32'sd0;
        tick;
        ap_start = 1'b0; din0 = -14'sd8192; din1 = -7'sd64;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i % 2 == 0);
            #1;
            check_bit("t3_run_in_ready", in_ready, 1'b1);
            tick;
        end
        in_valid = 1'b1;
        #1;
        check_bit("t3_drain_in_ready", in_ready, 1'b0);
        res_ready = 1'b1;
        tick;
        #1;
        check_bit("t3_out_in_ready", in_ready, 1'b0);
        check_bit("t3_res_valid", res_valid, 1'b1);
        check_val("t3_res_data", 64'(res_data), 64'sd2097152);
        tick;
        in_valid = 1'b0; res_ready = 1'b0;
        #1;
        check_bit("t3_idle", ap_idle, 1'b1);

        // result held under back-pressure, ap_start ignored in OUT
        ap_start = 1'b1; len = 8'd1; bias = 32'sd0;
        tick;
        ap_start = 1'b0; in_valid = 1'b1; din0 = 14'sd5; din1 = -7'sd3;
        tick;
        in_valid = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            ap_start = (i % 2 == 0);
            #1;
            check_bit("t4_hold_valid", res_valid, 1'b1);
            check_val("t4_hold_data", 64'(res_data), -64'sd15);
            check_bit("t4_hold_no_done", ap_done, 1'b0);
            check_bit("t4_hold_no_ready", ap_ready, 1'b0);
            tick;
        end
        ap_start = 1'b0; res_ready = 1'b1;
        #1;
        check_bit("t4_release_done", ap_done, 1'b1);
        check_val("t4_release_data", 64'(res_data), -64'sd15);
        tick;
        res_ready = 1'b0;
        #1;
        check_bit("t4_idle", ap_idle, 1'b1);
        check_bit("t4_done_low", ap_done, 1'b0);

        // reset mid-job after two of five beats, then a fresh job: 3*3
        ap_start = 1'b1; len = 8'd5; bias = 32'sd100;
        tick;
        ap_start = 1'b0; in_valid = 1'b1; din0 = 14'sd1; din1 = 7'sd1;
        tick;
        din0 = 14'sd2; din1 = 7'sd2;
        tick;
        din0 = 14'sd3; din1 = 7'sd3;
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("t5_rst_idle", ap_idle, 1'b1);
        check_bit("t5_rst_in_ready", in_ready, 1'b0);
        check_bit("t5_rst_res_valid", res_valid, 1'b0);
        check_val("t5_rst_res_data", 64'(res_data), 64'sd0);
        check_bit("t5_rst_done", ap_done, 1'b0);
        check_bit("t5_rst_ready", ap_ready, 1'b0);
        in_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        ap_start = 1'b1; len = 8'd1; bias = 32'sd0;
        #1;
        check_bit("t5_new_ap_ready", ap_ready, 1'b1);
        tick;
        ap_start = 1'b0; in_valid = 1'b1; din0 = 14'sd3; din1 = 7'sd3;
        tick;
        in_valid = 1'b0;
        #1;
        check_bit("t5_drain_in_ready", in_ready, 1'b0);
        tick;
        #1;
        check_bit("t5_res_valid", res_valid, 1'b1);
        check_val("t5_res_data", 64'(res_data), 64'sd9);
        res_ready = 1'b1;
        #1;
        check_bit("t5_ap_done", ap_done, 1'b1);
        tick;
        res_ready = 1'b0;

        // 21-bit accumulator wraps: 1048575 + 1
        w_ap_start = 1'b1; w_len = 8'd1; w_bias = 21'sd1048575;
        tick;
        w_ap_start = 1'b0; w_in_valid = 1'b1; w_din0 = 14'sd1; w_din1 = 7'sd1;
        tick;
        w_in_valid = 1'b0;
        tick;
        #1;
        check_bit("t6_res_valid", w_res_valid, 1'b1);
        check_val("t6_res_data_wrap", 64'(w_res_data), -64'sd1048576);
        w_res_ready = 1'b1;
        #1;
        check_bit("t6_ap_done", w_ap_done, 1'b1);
        tick;
        w_res_ready = 1'b0;
        #1;
        check_bit("t6_idle", w_ap_idle, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_mac_seq.md
CNN_MAC_SEQ -- requirements
Module: cnn_mac_seq

Interface
REQ-001 Parameter DIN0_WIDTH, default 14, signed activation operand width.
REQ-002 Parameter DIN1_WIDTH, default 7, signed weight operand width.
REQ-003 Parameter ACC_WIDTH, default 32, signed accumulator/result width; SHALL be at least DIN0_WIDTH+DIN1_WIDTH.
REQ-004 Parameter LEN_WIDTH, default 8, width of the beat-count field.
REQ-005 ap_clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 ap_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 ap_start  in  1  request to begin one dot-product job.
REQ-008 ap_ready  out  1  one-cycle pulse when a job is accepted.
REQ-009 ap_idle  out  1  high while in IDLE.
REQ-010 ap_done  out  1  one-cycle pulse on the result handshake cycle.
REQ-011 len  in  LEN_WIDTH  unsigned operand-pair count; sampled at acceptance.
REQ-012 bias  in  ACC_WIDTH  signed initial accumulator value; sampled at acceptance.
REQ-013 in_valid  in  1  operand pair valid.
REQ-014 in_ready  out  1  block accepts an operand pair.
REQ-015 din0  in  DIN0_WIDTH  signed activation.
REQ-016 din1  in  DIN1_WIDTH  signed weight.
REQ-017 res_valid  out  1  result valid, held until accepted.
REQ-018 res_ready  in  1  downstream accepts result.
REQ-019 res_data  out  ACC_WIDTH  signed accumulated result.

Function
REQ-020 States SHALL be IDLE, RUN, DRAIN, OUT.
REQ-021 IDLE: ap_idle=1, in_ready=0, res_valid=0; ap_start=1 -> ap_ready pulse, latch len and load bias into accumulator, clear beat counter; next RUN if len>0, OUT if len==0.
REQ-022 ap_start outside IDLE SHALL be ignored (no ap_ready, no state change).
REQ-023 RUN: in_ready=1; a beat is transferred when in_valid && in_ready.
REQ-024 Each transferred beat SHALL register the full-precision signed product din0*din1 (DIN0_WIDTH+DIN1_WIDTH bits) into a one-stage product register with a valid flag.
REQ-025 Each cycle the product valid flag is set, accumulator SHALL add the sign-extended product; addition wraps modulo 2^ACC_WIDTH, no saturation.
REQ-026 Beat counter increments per transfer; transfer of beat number len SHALL move RUN -> DRAIN; in_ready SHALL be 0 from the following cycle.
REQ-027 DRAIN: one cycle in which the final product is accumulated; then OUT.
REQ-028 OUT: res_valid=1, res_data=accumulator, both stable until res_ready=1; on handshake ap_done pulses and state returns to IDLE.
REQ-029 Latency: last beat transferred in cycle t -> res_valid high in cycle t+2.
REQ-030 in_valid gaps in RUN SHALL stall without loss; back-to-back beats SHALL sustain one beat per cycle.
REQ-031 res_ready held high entering OUT SHALL complete handshake in the first OUT cycle; new ap_start is accepted no earlier than the following cycle (IDLE).
REQ-032 len==0 SHALL produce res_data=bias with no beats consumed.

Reset
REQ-033 ap_rst_n=0 at any time, including mid-job, SHALL immediately force IDLE, counter=0, accumulator=0, product valid=0, ap_idle=1, ap_ready=0, ap_done=0, in_ready=0, res_valid=0, res_data=0.
REQ-034 After ap_rst_n deasserts, first job acceptance SHALL be possible on the next ap_start in IDLE; partial job state is discarded.

Verification
REQ-035 len=3, bias=10, pairs (100,2),(−50,3),(8191,−64) back-to-back, res_ready=1 -> res_data=10+200−150−524224=−524164, res_valid 2 cycles after third beat, one ap_done pulse.
REQ-036 len=0, bias=−7 -> no in_ready, res_valid with res_data=−7, ap_done on handshake.
REQ-037 len=4, pairs (−8192,−64) each, in_valid toggling 1/0, bias=0 -> res_data=2097152, four beats consumed only.
REQ-038 res_ready held 0 for 5 cycles in OUT -> res_valid and res_data stable, ap_start pulses ignored, ap_done only on release cycle.
REQ-039 ap_rst_n asserted after 2 of 5 beats -> all outputs reset values same cycle; fresh job len=1 (3,3), bias=0 -> res_data=9.
REQ-040 ACC_WIDTH=21, bias=1048575, pair (1,1) -> wrapped res_data=−1048576.
